// File: rtl/carregador_memorias_acesso_externo.sv
// Stream loader: decodes framed load commands from a byte stream and drives the
// write ports of the relations and obstacles memories.
module carregador_memorias_acesso_externo #(
  parameter int ADDR_WIDTH          = 8,
  parameter int RELACOES_DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     stream_data_in,
  input  logic                           stream_valid_in,
  output logic                           stream_ready_out,
  output logic                           relacoes_wr_en_out,
  output logic [ADDR_WIDTH-1:0]          relacoes_wr_addr_out,
  output logic [RELACOES_DATA_WIDTH-1:0] relacoes_wr_data_out,
  output logic                           obstaculos_wr_en_out,
  output logic [ADDR_WIDTH-1:0]          obstaculos_wr_addr_out,
  output logic                           obstaculos_wr_data_out,
  output logic                           busy_out,
  output logic                           done_out,
  output logic                           erro_out,
  output logic [2:0]                     fsm_state_out
);

  // Handshake: a byte transfers on a rising edge where stream_valid_in and
  // stream_ready_out are both 1; ready depends only on internal state.
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA, S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic                           is_obst_q, is_obst_d;
  logic [7:0]                     addr_hi_q, addr_hi_d;
  logic [7:0]                     cnt_hi_q, cnt_hi_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [15:0]                    cnt_q, cnt_d;
  logic [7:0]                     shift_q, shift_d;
  logic [2:0]                     bits_q, bits_d;
  logic                           erro_q, erro_d;
  logic                           rel_en_q, rel_en_d;
  logic [ADDR_WIDTH-1:0]          rel_addr_q, rel_addr_d;
  logic [RELACOES_DATA_WIDTH-1:0] rel_data_q, rel_data_d;
  logic                           obs_en_q, obs_en_d;
  logic [ADDR_WIDTH-1:0]          obs_addr_q, obs_addr_d;
  logic                           obs_data_q, obs_data_d;
  logic                           ready;
  logic                           accept;

  always_comb begin
    state_d    = state_q;
    is_obst_d  = is_obst_q;
    addr_hi_d  = addr_hi_q;
    cnt_hi_d   = cnt_hi_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bits_d     = bits_q;
    erro_d     = erro_q;
    rel_en_d   = 1'b0;
    rel_addr_d = rel_addr_q;
    rel_data_d = rel_data_q;
    obs_en_d   = 1'b0;
    obs_addr_d = obs_addr_q;
    obs_data_d = obs_data_q;
    ready      = 1'b0;

    case (state_q)
      S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L: ready = 1'b1;
      S_DATA: begin
        if (cnt_q != 16'd0) begin
          if (!is_obst_q) ready = 1'b1;
          else            ready = (bits_q == 3'd0) && !obs_en_q;
        end
      end
      default: ready = 1'b0;
    endcase
    ready  = ready & rst_n;
    accept = ready & stream_valid_in;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (stream_data_in == 8'h01 || stream_data_in == 8'h02) begin
            is_obst_d = (stream_data_in == 8'h02);
            erro_d    = 1'b0;
            state_d   = S_ADDR_H;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      S_ADDR_H: begin
        if (accept) begin
          addr_hi_d = stream_data_in;
          state_d   = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (accept) begin
          addr_d  = ADDR_WIDTH'({addr_hi_q, stream_data_in});
          state_d = S_CNT_H;
        end
      end
      S_CNT_H: begin
        if (accept) begin
          cnt_hi_d = stream_data_in;
          state_d  = S_CNT_L;
        end
      end
      S_CNT_L: begin
        if (accept) begin
          cnt_d   = {cnt_hi_q, stream_data_in};
          bits_d  = 3'd0;
          state_d = ({cnt_hi_q, stream_data_in} == 16'd0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DONE;
        end else if (!is_obst_q) begin
          if (accept) begin
            rel_en_d   = 1'b1;
            rel_addr_d = addr_q;
            rel_data_d = RELACOES_DATA_WIDTH'(stream_data_in);
            addr_d     = addr_q + ADDR_WIDTH'(1);
            cnt_d      = cnt_q - 16'd1;
          end
        end else if (bits_q != 3'd0) begin
          obs_en_d   = 1'b1;
          obs_addr_d = addr_q;
          obs_data_d = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          bits_d     = bits_q - 3'd1;
          addr_d     = addr_q + ADDR_WIDTH'(1);
          cnt_d      = cnt_q - 16'd1;
        end else if (accept) begin
          // Bit 0 goes out immediately; bits_d counts the bits still held in shift_q.
          obs_en_d   = 1'b1;
          obs_addr_d = addr_q;
          obs_data_d = stream_data_in[0];
          shift_d    = {1'b0, stream_data_in[7:1]};
          bits_d     = (cnt_q >= 16'd8) ? 3'd7 : (cnt_q[2:0] - 3'd1);
          addr_d     = addr_q + ADDR_WIDTH'(1);
          cnt_d      = cnt_q - 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_obst_q  <= 1'b0;
      addr_hi_q  <= '0;
      cnt_hi_q   <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      bits_q     <= '0;
      erro_q     <= 1'b0;
      rel_en_q   <= 1'b0;
      rel_addr_q <= '0;
      rel_data_q <= '0;
      obs_en_q   <= 1'b0;
      obs_addr_q <= '0;
      obs_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_obst_q  <= is_obst_d;
      addr_hi_q  <= addr_hi_d;
      cnt_hi_q   <= cnt_hi_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bits_q     <= bits_d;
      erro_q     <= erro_d;
      rel_en_q   <= rel_en_d;
      rel_addr_q <= rel_addr_d;
      rel_data_q <= rel_data_d;
      obs_en_q   <= obs_en_d;
      obs_addr_q <= obs_addr_d;
      obs_data_q <= obs_data_d;
    end
  end

  assign stream_ready_out       = ready;
  assign relacoes_wr_en_out     = rel_en_q;
  assign relacoes_wr_addr_out   = rel_addr_q;
  assign relacoes_wr_data_out   = rel_data_q;
  assign obstaculos_wr_en_out   = obs_en_q;
  assign obstaculos_wr_addr_out = obs_addr_q;
  assign obstaculos_wr_data_out = obs_data_q;
  assign busy_out               = (state_q != S_IDLE);
  assign done_out               = (state_q == S_DONE);
  assign erro_out               = erro_q;
  assign fsm_state_out          = state_q;

endmodule

// File: tb/tb_carregador_memorias_acesso_externo.sv
// Bench for the stream loader: frames are decoded by a reference model into an
// expected write list that a per-cycle compare process consumes.
module tb_carregador_memorias_acesso_externo;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int W  = 25; // {is_obst, addr[15:0], data[7:0]}

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    stream_data_in = 8'h00;
  logic          stream_valid_in = 1'b0;
  logic          stream_ready_out;
  logic          rel_en, obs_en, obs_data, busy, done, erro;
  logic [AW-1:0] rel_addr, obs_addr;
  logic [DW-1:0] rel_data;
  logic [2:0]    fsm_state;

  carregador_memorias_acesso_externo #(.ADDR_WIDTH(AW), .RELACOES_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .stream_data_in(stream_data_in), .stream_valid_in(stream_valid_in),
    .stream_ready_out(stream_ready_out),
    .relacoes_wr_en_out(rel_en), .relacoes_wr_addr_out(rel_addr),
    .relacoes_wr_data_out(rel_data),
    .obstaculos_wr_en_out(obs_en), .obstaculos_wr_addr_out(obs_addr),
    .obstaculos_wr_data_out(obs_data),
    .busy_out(busy), .done_out(done), .erro_out(erro), .fsm_state_out(fsm_state)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   frame_q[$];
  int wr_cyc_q[$];
  int acc_q[$];
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_cycle = 0;
  bit exp_err, exp_done;
  int exp_nwr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Compare process: every strobe must match the head of the expected list.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rel_en && obs_en) check("both_strobes", 1, 0);
      if (obs_en && stream_ready_out) check("ready_during_emit", 1, 0);
      if (rel_en) begin
        if (exp_q.size() == 0) check("extra_rel_write", 1, 0);
        else check("rel_write", 32'({1'b0, 16'(rel_addr), 8'(rel_data)}), 32'(exp_q.pop_front()));
        wr_cnt++;
        wr_cyc_q.push_back(cycle);
      end
      if (obs_en) begin
        if (exp_q.size() == 0) check("extra_obs_write", 1, 0);
        else check("obs_write", 32'({1'b1, 16'(obs_addr), 7'd0, obs_data}), 32'(exp_q.pop_front()));
        wr_cnt++;
        wr_cyc_q.push_back(cycle);
      end
      if (done) begin
        done_cnt++;
        done_cycle = cycle;
        check("done_after_writes", exp_q.size(), 0);
      end
    end
  end

  // Reference model: frame bytes -> list of memory writes.
  task automatic build_expected();
    logic [7:0]  cmd;
    logic [15:0] base, n, a;
    logic [7:0]  b;
    cmd = frame_q[0];
    exp_q.delete();
    if (cmd != 8'h01 && cmd != 8'h02) begin
      exp_err = 1'b1; exp_done = 1'b0; exp_nwr = 0;
      return;
    end
    exp_err = 1'b0; exp_done = 1'b1;
    base = {frame_q[1], frame_q[2]};
    n    = {frame_q[3], frame_q[4]};
    exp_nwr = int'(n);
    for (int i = 0; i < int'(n); i++) begin
      a = 16'((int'(base) + i) % (1 << AW));
      if (cmd == 8'h01) begin
        b = frame_q[5 + i];
        exp_q.push_back({1'b0, a, 8'(int'(b) % (1 << DW))});
      end else begin
        b = frame_q[5 + i / 8];
        exp_q.push_back({1'b1, a, 7'd0, b[i % 8]});
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    stream_valid_in = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    stream_valid_in = 1'b1;
    stream_data_in  = b;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (stream_ready_out) begin
        @(posedge clk); #1;
        ok = 1'b1;
        acc_q.push_back(cycle);
      end
    end
    stream_valid_in = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic run_frame(input int gap_max);
    int w0, d0;
    build_expected();
    w0 = wr_cnt;
    d0 = done_cnt;
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], $urandom_range(gap_max, 0));
      if (i == 0 && exp_done) check("erro_clear_on_cmd", erro, 0);
    end
    if (exp_done) begin
      for (int k = 0; k < 300 && done_cnt == d0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      check("done_pulses", done_cnt - d0, 1);
      if (exp_nwr > 0) check("done_timing", done_cycle - wr_cyc_q[$], 1);
    end else begin
      repeat (3) @(posedge clk);
      check("no_done_on_bad_cmd", done_cnt - d0, 0);
      check("state_idle_after_bad", fsm_state, 0);
    end
    #1;
    check("write_count", wr_cnt - w0, exp_nwr);
    check("erro_flag", erro, exp_err);
    check("busy_after_frame", busy, 0);
  endtask

  initial begin
    // Reset: all outputs low, ready low.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({stream_ready_out, rel_en, rel_addr, rel_data, obs_en,
                                obs_addr, obs_data, busy, done, erro}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", stream_ready_out, 1);

    // Relations frame, valid held high.
    frame_q = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    build_expected();
    check("model_pin_rel0", 32'(exp_q[0]), 32'({1'b0, 16'h0010, 8'hAA}));
    check("model_pin_rel2", 32'(exp_q[2]), 32'({1'b0, 16'h0012, 8'hCC}));
    run_frame(0);
    check("rel_consecutive", wr_cyc_q[$] - wr_cyc_q[wr_cyc_q.size() - 3], 2);

    // Obstacles frame: 10 bits from two bytes, 9-cycle byte period.
    frame_q = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h0A, 8'hA5, 8'h03};
    build_expected();
    check("model_pin_obs0", 32'(exp_q[0]), 32'({1'b1, 16'h0020, 8'h01}));
    check("model_pin_obs1", 32'(exp_q[1]), 32'({1'b1, 16'h0021, 8'h00}));
    check("model_pin_obs9", 32'(exp_q[9]), 32'({1'b1, 16'h0029, 8'h01}));
    run_frame(0);
    check("obs_byte_period", acc_q[$] - acc_q[acc_q.size() - 2], 9);

    // Address wrap.
    frame_q = '{8'h01, 8'h00, 8'hFE, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    build_expected();
    check("model_pin_wrap", 32'(exp_q[2]), 32'({1'b0, 16'h0000, 8'h33}));
    run_frame(0);

    // Unknown command, then a valid frame clears the error.
    frame_q = '{8'h7F};
    run_frame(0);
    frame_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h55};
    run_frame(1);

    // Zero-length frame.
    frame_q = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h00};
    run_frame(0);

    // Reset in the middle of a relations payload.
    frame_q = '{8'h01, 8'h00, 8'h40, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    build_expected();
    for (int i = 0; i < 7; i++) send_byte(frame_q[i], 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({stream_ready_out, rel_en, rel_addr, rel_data, obs_en,
                                   obs_addr, obs_data, busy, done, erro}), 0);
    check("midreset_pending_writes", exp_q.size(), 2);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    frame_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    run_frame(0);

    // Randomized frames with random valid gaps.
    for (int f = 0; f < 25; f++) begin
      logic [7:0]  cmd;
      logic [15:0] n;
      int nb;
      cmd = ($urandom_range(9, 0) == 0) ? 8'($urandom_range(255, 3))
                                        : 8'($urandom_range(2, 1));
      n = 16'($urandom_range(20, 0));
      frame_q.delete();
      frame_q.push_back(cmd);
      if (cmd == 8'h01 || cmd == 8'h02) begin
        frame_q.push_back(8'($urandom_range(255, 0)));
        frame_q.push_back(8'($urandom_range(255, 0)));
        frame_q.push_back(n[15:8]);
        frame_q.push_back(n[7:0]);
        nb = (cmd == 8'h01) ? int'(n) : (int'(n) + 7) / 8;
        for (int i = 0; i < nb; i++) frame_q.push_back(8'($urandom_range(255, 0)));
      end
      run_frame(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/carregador_memorias_acesso_externo.md
Name: carregador_memorias_acesso_externo

Overview:
- Write-side counterpart of the external read path into the relations and obstacles memories.
- Accepts a byte stream from the host or bridge over a valid/ready handshake and decodes framed load commands.
- Drives the write ports of mem_relacoes and mem_obstaculos, so the path-search engine can later read the loaded graph and obstacle map.
- Lets the graph and map be loaded at runtime instead of only at synthesis time.

Parameters:
- ADDR_WIDTH, 8, memory address width; legal range 1..16.
- RELACOES_DATA_WIDTH, 8, relations word width; legal range 1..8. Each stream byte carries one word in its low bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stream_data_in  input  8  incoming byte.
- stream_valid_in  input  1  byte valid.
- stream_ready_out  output  1  block can accept a byte. Transfer happens when valid and ready are both 1.
- relacoes_wr_en_out  output  1  relations write strobe.
- relacoes_wr_addr_out  output  ADDR_WIDTH  relations write address.
- relacoes_wr_data_out  output  RELACOES_DATA_WIDTH  relations write data.
- obstaculos_wr_en_out  output  1  obstacles write strobe.
- obstaculos_wr_addr_out  output  ADDR_WIDTH  obstacles write address.
- obstaculos_wr_data_out  output  1  obstacles write bit.
- busy_out  output  1  a frame is in progress (any state other than IDLE).
- done_out  output  1  one-cycle pulse when a frame completes.
- erro_out  output  1  sticky error flag: unknown command.

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE and all counters and shift registers clear. Reset mid-frame abandons the frame; words already written stay in memory. stream_ready_out is 0 during reset.
- Frame format, all bytes consumed in this order:
  - CMD: 0x01 = relations, 0x02 = obstacles.
  - ADDR_H, ADDR_L: start address, big-endian; only the low ADDR_WIDTH bits are used.
  - CNT_H, CNT_L: word count N, 16 bits.
  - Payload.
- FSM states: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA, DONE.
  - stream_ready_out = 1 in IDLE, ADDR_H, ADDR_L, CNT_H and CNT_L.
  - In DATA, ready follows the rules below. In DONE, ready = 0.
- IDLE:
  - Accepted CMD 0x01 or 0x02: latch the command, clear erro_out, go to ADDR_H.
  - Any other CMD: set erro_out and stay in IDLE. The byte is consumed.
- CNT_L accepted with N = 0: go directly to DONE; no writes occur.
- Relations payload: N bytes, one per word.
  - A byte accepted at cycle t gives relacoes_wr_en_out = 1 at t+1, with addr = current address and data = byte[RELACOES_DATA_WIDTH-1:0].
  - Ready stays 1, so throughput is one word per cycle.
- Obstacles payload: ceil(N/8) bytes, LSB first; bit i of a byte maps to address base + 8*k + i.
  - After a byte is accepted, ready = 0 while bits remain to be emitted.
  - Writes occur one bit per cycle starting the next cycle, k = min(8, remaining) writes.
  - Ready returns to 1 the cycle after the last of those writes, so a full byte takes 9 cycles.
  - Unused high bits of the final partial byte are discarded.
- Address arithmetic:
  - The address increments by 1 after every write, modulo 2^ADDR_WIDTH. Wrap from all-ones to 0 is silent.
  - The word counter decrements per write. The write that brings it to 0 moves the FSM to DONE on the next cycle.
- DONE: done_out = 1 for exactly one cycle, then the FSM returns to IDLE.
- Other timing:
  - Write strobes are registered, one cycle wide per word.
  - Both strobes are never high in the same cycle; the strobe for the unselected memory stays 0.
  - stream_valid_in low in any state: the FSM holds, with no writes and no timeouts.
- Data bytes received while in IDLE are interpreted as CMD. There is no resynchronisation beyond this.

Test Plan:
- Relations frame 01 00 10 00 03 AA BB CC, valid held high → writes (0x10,AA), (0x11,BB), (0x12,CC) on consecutive cycles; done_out pulses the cycle after the last write; erro_out = 0.
- Obstacles frame 02 00 20 00 0A A5 03 → writes to addr 0x20..0x27 with bits 1,0,1,0,0,1,0,1, then 0x28 = 1 and 0x29 = 1; ready low during bit emission; exactly 10 strobes; one done pulse.
- ADDR_WIDTH = 8, relations frame start 0xFE, N = 3 → writes at 0xFE, 0xFF, 0x00.
- CMD 0x7F → erro_out = 1, no writes, FSM in IDLE. A following valid frame 01 00 00 00 01 55 → erro_out clears when the CMD is accepted; one write (0x00,55).
- Frame 01 00 05 00 00 → no strobes; done_out pulses; busy_out falls after DONE.
- rst_n asserted after 2 of 4 relations payload bytes → all outputs 0 immediately; after release a new frame 02 00 00 00 01 01 → single obstacle write (0x00,1).
